// File: rtl/decomp_pkg.sv
// Shared definitions for the decompressor datapath: owner encoding for the
// frame-RAM arbiter and default RAM geometry.
package decomp_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } own_e;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin picker: on a tie the requester that was not granted
// last wins; a lone requester always wins.
module rr_pick2 (
  input  logic       req0_i,
  input  logic       req1_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = '0;
    if (req0_i && req1_i) begin
      gnt_o = last_i ? 2'b01 : 2'b10;
    end else if (req0_i) begin
      gnt_o = 2'b01;
    end else if (req1_i) begin
      gnt_o = 2'b10;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Frame-RAM port arbiter between the decompressor (P0) and reorder controller
// (P1): round-robin with a bounded burst lock and 1-cycle read-valid tracking.
module mem_port_arbiter
  import decomp_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              lock0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic              lock1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

  own_e          own_q, own_d;
  logic          last_q, last_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          rvalid0_q, rvalid0_d;
  logic          rvalid1_q, rvalid1_d;

  logic [1:0] rr_gnt;
  logic [1:0] gnt;
  logic       keep0, keep1;
  own_e       win_own;
  logic       win_lock;

  rr_pick2 u_pick (
    .req0_i (req0),
    .req1_i (req1),
    .last_i (last_q),
    .gnt_o  (rr_gnt)
  );

  // A live lock keeps the port unless the hold budget is spent and the
  // other side is actually waiting.
  assign keep0 = (own_q == OWN_P0) && req0 && ((hold_q < HOLD_MAX) || !req1);
  assign keep1 = (own_q == OWN_P1) && req1 && ((hold_q < HOLD_MAX) || !req0);

  always_comb begin
    gnt = '0;
    if (rst) begin
      gnt = '0;
    end else if (keep0) begin
      gnt = 2'b01;
    end else if (keep1) begin
      gnt = 2'b10;
    end else begin
      gnt = rr_gnt;
    end
  end

  assign gnt0 = gnt[0];
  assign gnt1 = gnt[1];

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt[0]) begin
      mem_en    = 1'b1;
      mem_we    = we0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end else if (gnt[1]) begin
      mem_en    = 1'b1;
      mem_we    = we1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end
  end

  always_comb begin
    own_d     = OWN_NONE;
    last_d    = last_q;
    hold_d    = '0;
    win_own   = gnt[1] ? OWN_P1 : OWN_P0;
    win_lock  = gnt[1] ? lock1 : lock0;
    rvalid0_d = gnt[0] && !we0;
    rvalid1_d = gnt[1] && !we1;
    if (gnt != 2'b00) begin
      last_d = gnt[1];
      own_d  = win_lock ? win_own : OWN_NONE;
      // A new winner (including a forced hand-over) restarts its count at 1.
      if (own_q == win_own) begin
        hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
      end else begin
        hold_d = HW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      own_q     <= OWN_NONE;
      last_q    <= 1'b1;
      hold_q    <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      own_q     <= own_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata   = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small synchronous RAM model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, lock0, we0, req1, lock1, we1;
  logic [15:0] addr0, addr1;
  logic [7:0]  wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0]  rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic [7:0]  ram [0:65535];

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(8), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .lock0(lock0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0),
    .req1(req1), .lock1(lock1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1),
    .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic r, input logic l, input logic w, input logic [15:0] a, input logic [7:0] d);
    req0 = r; lock0 = l; we0 = w; addr0 = a; wdata0 = d;
  endtask

  task automatic drv1(input logic r, input logic l, input logic w, input logic [15:0] a, input logic [7:0] d);
    req1 = r; lock1 = l; we1 = w; addr1 = a; wdata1 = d;
  endtask

  initial begin
    ram[16'h0010] = 8'hA5;
    mem_rdata = 8'h00;
    rst = 1'b1;
    drv0(0, 0, 0, 16'h0, 8'h0);
    drv1(0, 0, 0, 16'h0, 8'h0);
    tick(); tick();
    rst = 1'b0;
    #2;
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rvalid0", rvalid0, 0);
    chk("rst_rvalid1", rvalid1, 0);

    // Single read by P0
    tick();
    drv0(1, 0, 0, 16'h0010, 8'h00);
    #2;
    chk("rd0_gnt0", gnt0, 1);
    chk("rd0_gnt1", gnt1, 0);
    chk("rd0_mem_en", mem_en, 1);
    chk("rd0_mem_we", mem_we, 0);
    chk("rd0_mem_addr", mem_addr, 16'h0010);
    tick();
    drv0(0, 0, 0, 16'h0, 8'h0);
    #2;
    chk("rd0_rvalid0", rvalid0, 1);
    chk("rd0_rdata", rdata, 8'hA5);
    chk("rd0_rvalid1", rvalid1, 0);
    chk("rd0_idle_en", mem_en, 0);

    // P1 write then read-back
    tick();
    drv1(1, 0, 1, 16'h0020, 8'h5A);
    #2;
    chk("wr1_gnt1", gnt1, 1);
    chk("wr1_mem_we", mem_we, 1);
    chk("wr1_mem_addr", mem_addr, 16'h0020);
    chk("wr1_mem_wdata", mem_wdata, 8'h5A);
    tick();
    drv1(1, 0, 0, 16'h0020, 8'h00);
    #2;
    chk("wr1_no_rvalid", rvalid1, 0);
    chk("rb1_gnt1", gnt1, 1);
    tick();
    drv1(0, 0, 0, 16'h0, 8'h0);
    #2;
    chk("rb1_rvalid1", rvalid1, 1);
    chk("rb1_rdata", rdata, 8'h5A);
    chk("rb1_rvalid0", rvalid0, 0);

    // Tie without locks alternates, starting with P0 (last grant was P1)
    tick();
    drv0(1, 0, 0, 16'h0010, 8'h0);
    drv1(1, 0, 0, 16'h0020, 8'h0);
    for (int k = 0; k < 6; k++) begin
      #2;
      chk("alt_gnt0", gnt0, (k % 2 == 0) ? 1 : 0);
      chk("alt_gnt1", gnt1, (k % 2 == 0) ? 0 : 1);
      tick();
    end
    drv0(0, 0, 0, 16'h0, 8'h0);
    drv1(0, 0, 0, 16'h0, 8'h0);

    // Make P0 the last winner, then P1 locks against a waiting P0
    tick();
    drv0(1, 0, 0, 16'h0010, 8'h0);
    tick();
    drv0(0, 0, 0, 16'h0, 8'h0);
    tick();
    drv0(1, 0, 0, 16'h0010, 8'h0);
    drv1(1, 1, 0, 16'h0020, 8'h0);
    for (int k = 0; k < 10; k++) begin
      #2;
      chk("hold_gnt1", gnt1, (k == 4 || k == 9) ? 0 : 1);
      chk("hold_gnt0", gnt0, (k == 4 || k == 9) ? 1 : 0);
      tick();
    end
    drv0(0, 0, 0, 16'h0, 8'h0);
    drv1(0, 0, 0, 16'h0, 8'h0);
    tick();

    // P1 locked alone: no limit, then a waiting P0 gets in at once
    drv1(1, 1, 0, 16'h0020, 8'h0);
    for (int k = 0; k < 10; k++) begin
      #2;
      chk("solo_gnt1", gnt1, 1);
      tick();
    end
    drv0(1, 0, 0, 16'h0010, 8'h0);
    #2;
    chk("sat_gnt0", gnt0, 1);
    chk("sat_gnt1", gnt1, 0);
    tick();
    drv0(0, 0, 0, 16'h0, 8'h0);
    drv1(0, 0, 0, 16'h0, 8'h0);
    tick();

    // Owner P1 drops request mid-lock; P0 takes over with its own lock
    drv1(1, 1, 0, 16'h0020, 8'h0);
    tick(); tick();
    drv1(0, 0, 0, 16'h0, 8'h0);
    drv0(1, 1, 0, 16'h0010, 8'h0);
    #2;
    chk("drop_gnt0", gnt0, 1);
    chk("drop_gnt1", gnt1, 0);
    tick();
    drv1(1, 0, 0, 16'h0020, 8'h0);
    #2;
    chk("own0_gnt0", gnt0, 1);
    tick();
    drv0(1, 0, 0, 16'h0010, 8'h0);
    #2;
    chk("own0b_gnt0", gnt0, 1);
    tick();
    #2;
    chk("rel_gnt1", gnt1, 1);
    chk("rel_gnt0", gnt0, 0);
    tick();
    drv0(0, 0, 0, 16'h0, 8'h0);
    drv1(0, 0, 0, 16'h0, 8'h0);
    tick();

    // Reset during a read burst
    drv0(1, 0, 0, 16'h0010, 8'h0);
    tick();
    #2;
    chk("pre_rst_rvalid0", rvalid0, 1);
    chk("pre_rst_gnt0", gnt0, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_gnt0", gnt0, 0);
    chk("rst_mid_mem_en", mem_en, 0);
    chk("rst_mid_rvalid0", rvalid0, 0);
    tick();
    chk("rst_hold_rvalid0", rvalid0, 0);
    chk("rst_hold_rvalid1", rvalid1, 0);
    rst = 1'b0;
    drv1(1, 0, 0, 16'h0020, 8'h0);
    #2;
    chk("post_rst_tie_gnt0", gnt0, 1);
    chk("post_rst_tie_gnt1", gnt1, 0);
    tick();
    drv0(0, 0, 0, 16'h0, 8'h0);
    drv1(0, 0, 0, 16'h0, 8'h0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
